fifo_dump_scanner: RTL

Sequences the dump port of a `ufifo` queue (INBOX/OUTBOX) during display blanking. It walks dump positions from 0 upward and captures each valid entry into a double-buffered shadow array. The VGA text renderer then reads a stable snapshot with fixed one-cycle latency, and never drives the FIFO dump port itself. The block sits between the FIFO and the text renderer's hex-digit stage.

---
 rtl/fifo_dump_scanner.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_dump_scanner.sv
// fifo_dump_scanner: walks a ufifo dump port during blanking and captures the
// valid entries into a double-buffered shadow array. The renderer reads a
// stable front-bank snapshot with one-cycle latency while the next scan fills
// the back bank. A bank swap happens only on a completed scan.
//
// Handshake: there is no valid/ready pair. i_start is level-sampled only while
// idle (ignored during a scan). The FIFO answers each o_dmp_pos one cycle later
// on i_dmp_data/i_dmp_valid. o_done pulses for exactly one cycle per committed
// snapshot.
module fifo_dump_scanner #(
  parameter int LGFLEN = 5,
  parameter int DW     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [LGFLEN-1:0] o_dmp_pos,
  input  logic [DW-1:0]     i_dmp_data,
  input  logic              i_dmp_valid,
  input  logic [LGFLEN-1:0] i_rd_pos,
  output logic [DW-1:0]     o_rd_data,
  output logic              o_rd_valid,
  output logic [LGFLEN:0]   o_count,
  output logic              o_busy,
  output logic              o_done
);

  localparam int N = 1 << LGFLEN;
  localparam logic [LGFLEN-1:0] POS_MAX = LGFLEN'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]        state;
  logic              fsel;    // selects the front (renderer-visible) bank
  logic              cap_en;  // FIFO response for a position issued by this scan is present
  logic [LGFLEN-1:0] cp;      // next back-bank slot to fill
  logic [DW-1:0]     mem [2][N];

  logic              cap_write;
  logic              scan_end;
  logic [LGFLEN:0]   commit_count;

  // Capture and termination decode for the current SCAN cycle
  always_comb begin
    cap_write    = (state == S_SCAN) && cap_en && i_dmp_valid;
    scan_end     = (state == S_SCAN) && cap_en && (!i_dmp_valid || (cp == POS_MAX));
    commit_count = {1'b0, cp} + (LGFLEN + 1)'(i_dmp_valid);
  end

  // Scan sequencer: issue positions, count captures, commit and swap banks
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      fsel      <= 1'b0;
      cap_en    <= 1'b0;
      cp        <= '0;
      o_dmp_pos <= '0;
      o_count   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state     <= S_SCAN;
            o_dmp_pos <= '0;
            cp        <= '0;
            cap_en    <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        S_SCAN: begin
          // Issue pointer runs one position ahead of capture; saturate at the
          // last slot so the dump port never sees an out-of-range position.
          if (o_dmp_pos != POS_MAX) o_dmp_pos <= o_dmp_pos + 1'b1;
          cap_en <= 1'b1;
          if (cap_write) cp <= cp + 1'b1;
          if (scan_end) begin
            // The speculatively issued next position is simply dropped.
            state     <= S_IDLE;
            o_count   <= commit_count;
            fsel      <= ~fsel;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_dmp_pos <= '0;
            cap_en    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Back-bank write; bank contents are deliberately left unreset
  always_ff @(posedge i_clk) begin
    if (cap_write) mem[~fsel][cp] <= i_dmp_data;
  end

  // Registered renderer read of the front bank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_data  <= mem[fsel][i_rd_pos];
      o_rd_valid <= ({1'b0, i_rd_pos} < o_count);
    end
  end

endmodule
